// File: rtl/snn_layer_seq.sv
// snn_layer_seq: steps one fully-connected layer through the shared MAC.
// It produces one output neuron at a time. For each neuron it clears the
// MAC, issues N_IN operand addresses, waits out the memory and LUT latency,
// and then writes the activation to the destination RAM.
module snn_layer_seq #(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 32,
    parameter int IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    parameter int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              act_rd,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr
);

    localparam logic [IN_AW-1:0]  K_LAST    = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] N_LAST    = OUT_AW'(N_OUT - 1);
    localparam logic [W_AW-1:0]   BASE_STEP = W_AW'(N_IN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_BP1,
        S_BP2,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_AW-1:0]    r_k;
    logic [OUT_AW-1:0]   r_n;
    logic [W_AW-1:0]     r_base;
    logic                r_mac_vld_p1;

    // State register; reset drops any pass in flight so no write or done follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and decoded outputs; addresses are zero outside their states
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        in_addr     = '0;
        w_addr      = '0;
        mac_clr     = 1'b0;
        act_rd      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                mac_clr     = 1'b1;
                w_state_nxt = S_MAC;
            end
            S_MAC: begin
                in_addr = r_k;
                w_addr  = r_base + W_AW'(r_k);
                if (r_k == K_LAST) begin
                    w_state_nxt = S_BP1;
                end
            end
            S_BP1: begin
                w_state_nxt = S_BP2;
            end
            S_BP2: begin
                act_rd      = 1'b1;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_n;
                if (r_n == N_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CLR;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Neuron index, input index and weight base; base steps by N_IN so no multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_n    <= '0;
            r_base <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n    <= '0;
                        r_base <= '0;
                    end
                end
                S_CLR: begin
                    r_k <= '0;
                end
                S_MAC: begin
                    r_k <= r_k + 1'b1;
                end
                S_WRITE: begin
                    if (r_n != N_LAST) begin
                        r_n    <= r_n + 1'b1;
                        r_base <= r_base + BASE_STEP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // MAC enable trails the address by one cycle to match the synchronous read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_vld_p1 <= 1'b0;
        end else begin
            r_mac_vld_p1 <= (r_state == S_MAC);
        end
    end

    assign mac_en = r_mac_vld_p1;

endmodule

// File: tb/tb_snn_layer_seq.sv
// tb_snn_layer_seq: directed checks of the layer sequencer on three shapes
// (4x3, 784x32 and 1x2). Outputs are sampled on the falling edge, and inputs
// change on the falling edge.
module tb_snn_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4x3 instance
    logic       a_start, a_busy, a_done, a_clr, a_en, a_act, a_wr;
    logic [1:0] a_in, a_wra;
    logic [3:0] a_w;

    // 784x32 instance
    logic        b_start, b_busy, b_done, b_clr, b_en, b_act, b_wr;
    logic [9:0]  b_in;
    logic [14:0] b_w;
    logic [4:0]  b_wra;

    // 1x2 instance
    logic c_start, c_busy, c_done, c_clr, c_en, c_act, c_wr;
    logic c_in, c_w, c_wra;

    snn_layer_seq #(.N_IN(4), .N_OUT(3)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .in_addr(a_in), .w_addr(a_w), .mac_clr(a_clr), .mac_en(a_en),
        .act_rd(a_act), .wr_en(a_wr), .wr_addr(a_wra)
    );

    snn_layer_seq u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .in_addr(b_in), .w_addr(b_w), .mac_clr(b_clr), .mac_en(b_en),
        .act_rd(b_act), .wr_en(b_wr), .wr_addr(b_wra)
    );

    snn_layer_seq #(.N_IN(1), .N_OUT(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
        .in_addr(c_in), .w_addr(c_w), .mac_clr(c_clr), .mac_en(c_en),
        .act_rd(c_act), .wr_en(c_wr), .wr_addr(c_wra)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_a();
        return {18'b0, a_busy, a_done, a_clr, a_en, a_act, a_wr, a_in, a_w, a_wra};
    endfunction

    // Expected 4x3 outputs, with cycle 0 being the IDLE cycle that samples start (P = 8)
    function automatic logic [31:0] exp_a(input int c);
        logic       busy, dn, clr, en, act, wr;
        logic [1:0] ia, wra;
        logic [3:0] wa;
        int         j, r;
        busy = 0; dn = 0; clr = 0; en = 0; act = 0; wr = 0;
        ia = '0; wra = '0; wa = '0;
        if (c >= 1 && c <= 24) begin
            j    = (c - 1) / 8;
            r    = (c - 1) % 8;
            busy = 1'b1;
            clr  = (r == 0);
            if (r >= 1 && r <= 4) begin
                ia = 2'(r - 1);
                wa = 4'(j * 4 + r - 1);
            end
            en  = (r >= 2 && r <= 5);
            act = (r == 6);
            wr  = (r == 7);
            if (wr) wra = 2'(j);
        end else if (c == 25) begin
            busy = 1'b1;
            dn   = 1'b1;
        end
        return {18'b0, busy, dn, clr, en, act, wr, ia, wa, wra};
    endfunction

    // Runs a 4x3 pass starting at the falling edge of cycle 0
    task automatic run_a(input string name, input bit hold, input int pulse_c, input int n_cyc);
        int ec;
        for (int c = 0; c < n_cyc; c++) begin
            ec = (hold && c >= 26) ? c - 26 : c;
            chk($sformatf("%s_c%0d", name, c), obs_a(), exp_a(ec));
            a_start = (hold && c < 51) || (c == 0) || (c == pulse_c);
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    int          cnt_wr, cnt_en, done_c, n_done;
    logic [14:0] last_w;
    logic [31:0] exp_c;

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a", obs_a(), 32'd0);
        chk("rst_b", {b_busy, b_done, b_clr, b_en, b_act, b_wr, b_in, b_w, b_wra}, 32'd0);
        chk("rst_c", {c_busy, c_done, c_clr, c_en, c_act, c_wr, c_in, c_w, c_wra}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4x3 single pulse
        run_a("single", 1'b0, -1, 27);

        // 4x3 with an extra start while busy
        @(negedge clk);
        run_a("repulse", 1'b0, 10, 27);

        // 4x3 aborted by reset during neuron 1 MAC, then replayed
        @(negedge clk);
        for (int c = 0; c <= 12; c++) begin
            chk($sformatf("abort_c%0d", c), obs_a(), exp_a(c));
            a_start = (c == 0);
            if (c < 12) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_now", obs_a(), 32'd0);
        @(negedge clk);
        chk("abort_held", obs_a(), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", c), obs_a(), 32'd0);
        end
        run_a("replay", 1'b0, -1, 27);

        // 4x3 with start held high across two passes
        @(negedge clk);
        run_a("hold", 1'b1, -1, 53);

        // 1x2 pass
        @(negedge clk);
        for (int c = 0; c <= 12; c++) begin
            exp_c = {26'b0,
                     (c >= 1 && c <= 11), (c == 3 || c == 8), (c == 5 || c == 10),
                     (c == 11), (c == 10), (c == 7)};
            chk($sformatf("n1_c%0d", c), {26'b0, c_busy, c_en, c_wr, c_done, c_wra, c_w}, exp_c);
            c_start = (c == 0);
            @(negedge clk);
        end

        // 784x32 full pass
        cnt_wr = 0; cnt_en = 0; done_c = -1; n_done = 0; last_w = '0;
        for (int c = 0; c < 25300; c++) begin
            if (b_wr) cnt_wr++;
            if (b_en) cnt_en++;
            if (b_w != '0) last_w = b_w;
            if (b_done) begin
                done_c = c;
                n_done++;
            end
            if (c == 25216) chk("big_busy_hi", {31'b0, b_busy}, 32'd1);
            if (c == 25218) chk("big_busy_lo", {31'b0, b_busy}, 32'd0);
            b_start = (c == 0);
            @(negedge clk);
        end
        chk("big_done_cyc", done_c, 32'd25217);
        chk("big_done_cnt", n_done, 32'd1);
        chk("big_last_w", {17'b0, last_w}, 32'd25087);
        chk("big_wr_cnt", cnt_wr, 32'd32);
        chk("big_en_cnt", cnt_en, 32'd25088);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
